// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : Circular FIFO of word stores sitting between the core's memory
//             stage and data memory. Stores are drained in program order, one
//             per cycle while the memory accepts them. When the buffer is full
//             the core is stalled.
//  Revision : 1.0  initial release
//
//  Parameters
//    DEPTH  number of buffered stores (power of two, 2..16)
//    AW     byte-address width
//    DW     store-data width
//
//  Ports
//    clk, reset                     clock, synchronous active-high reset
//    memwritem/aluresultm/writedatam store request, address, data from core
//    stallm                          core holds its memory stage while high
//    mem_wvalid/mem_waddr/mem_wdata  head entry toward data memory
//    mem_wready                      memory accepts head entry this cycle
//    ld_addr, ld_hit, ld_data        load-forwarding lookup
//    count, empty                    occupancy status
//
//  Configuration
//    STORE_BUF_FWD_EN  when defined, buffered stores are forwarded to loads
//                      by word address (youngest match wins); otherwise
//                      ld_hit/ld_data are tied to zero.
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwritem,
  input  logic [AW-1:0]              aluresultm,
  input  logic [DW-1:0]              writedatam,
  output logic                       stallm,
  output logic                       mem_wvalid,
  output logic [AW-1:0]              mem_waddr,
  output logic [DW-1:0]              mem_wdata,
  input  logic                       mem_wready,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit,
  output logic [DW-1:0]              ld_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic full;
  logic enq;
  logic deq;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A dequeue in the same cycle does not make room: full is judged on the
  // registered count only, so a store arriving at a full buffer always stalls.
  assign enq    = memwritem && !full;
  assign stallm = memwritem && full;

  assign mem_wvalid = !empty;
  assign mem_waddr  = addr_q[head_q];
  assign mem_wdata  = data_q[head_q];
  // mem_wready is ignored while empty because mem_wvalid gates it.
  assign deq = mem_wvalid && mem_wready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PW'(1);
    if (deq) head_d = head_q + PW'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; it is only observable through valid entries.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      addr_q[tail_q] <= aluresultm;
      data_q[tail_q] <= writedatam;
    end
  end

`ifdef STORE_BUF_FWD_EN
  // Walk entries oldest to youngest from the head; a later match overrides an
  // earlier one, so the youngest matching store supplies ld_data. Only
  // registered entries are searched, so a same-cycle enqueue is not visible.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx][AW-1:2] == ld_addr[AW-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_q[idx];
      end
    end
  end
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr;
  assign ld_hit  = 1'b0;
  assign ld_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_buffer
//  Purpose  : Self-checking bench for store_buffer. A stimulus process drives
//             directed and random traffic, keeps a queue model of the buffer
//             and pushes expected outputs into scoreboard queues; a monitor
//             process pops and compares them at the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic           clk = 1'b0;
  logic           reset;
  logic           memwritem;
  logic [AW-1:0]  aluresultm;
  logic [DW-1:0]  writedatam;
  logic           stallm;
  logic           mem_wvalid;
  logic [AW-1:0]  mem_waddr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_wready;
  logic [AW-1:0]  ld_addr;
  logic           ld_hit;
  logic [DW-1:0]  ld_data;
  logic [CW-1:0]  count;
  logic           empty;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwritem  (memwritem),
    .aluresultm (aluresultm),
    .writedatam (writedatam),
    .stallm     (stallm),
    .mem_wvalid (mem_wvalid),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wready (mem_wready),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .ld_data    (ld_data),
    .count      (count),
    .empty      (empty)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } store_t;

  typedef struct {
    logic          stall;
    logic          valid;
    int            cnt;
    logic          hit;
    logic [DW-1:0] ldd;
  } exp_t;

  store_t mq[$];     // model contents of the buffer (oldest first)
  store_t exp_q[$];  // expected drain order toward memory
  exp_t   comb_q[$]; // expected combinational outputs, one per cycle

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares outputs against the scoreboard away from the rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (comb_q.size() > 0) begin
        exp_t e;
        e = comb_q.pop_front();
        chk("stallm",     stallm,     e.stall);
        chk("mem_wvalid", mem_wvalid, e.valid);
        chk("count",      count,      e.cnt);
        chk("empty",      empty,      (e.cnt == 0));
        chk("ld_hit",     ld_hit,     e.hit);
        chk("ld_data",    ld_data,    e.ldd);
      end
      if (mem_wvalid && mem_wready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          store_t s;
          s = exp_q.pop_front();
          chk("mem_waddr", mem_waddr, s.addr);
          chk("mem_wdata", mem_wdata, s.data);
        end
      end else if (mem_wvalid && exp_q.size() > 0) begin
        // head must be presented and held stable while memory is not ready
        chk("hold_waddr", mem_waddr, exp_q[0].addr);
        chk("hold_wdata", mem_wdata, exp_q[0].data);
      end
    end
  end

  // One clock cycle of stimulus plus its expectations.
  task automatic cyc(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic r, input logic [AW-1:0] la);
    exp_t   e;
    store_t st;
    int     n;
    logic   enq, deq;
    memwritem  = w;
    aluresultm = a;
    writedatam = d;
    mem_wready = r;
    ld_addr    = la;
    n       = mq.size();
    e.stall = w && (n == DEPTH);
    e.valid = (n > 0);
    e.cnt   = n;
    e.hit   = 1'b0;
    e.ldd   = '0;
`ifdef STORE_BUF_FWD_EN
    foreach (mq[i]) begin
      if (mq[i].addr[AW-1:2] == la[AW-1:2]) begin
        e.hit = 1'b1;
        e.ldd = mq[i].data;
      end
    end
`endif
    comb_q.push_back(e);
    st.addr = a;
    st.data = d;
    enq = w && (n < DEPTH);
    deq = (n > 0) && r;
    if (enq) exp_q.push_back(st);
    @(posedge clk);
    #1;
    if (deq) void'(mq.pop_front());
    if (enq) mq.push_back(st);
  endtask

  // Reset cycle: a store is offered but must not be captured.
  task automatic do_reset();
    reset      = 1'b1;
    memwritem  = 1'b1;
    aluresultm = 32'h0000_0FF0;
    writedatam = 32'hBAD0_BAD0;
    mem_wready = 1'b0;
    ld_addr    = '0;
    @(posedge clk);
    #1;
    mq.delete();
    exp_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    memwritem  = 1'b0;
    aluresultm = '0;
    writedatam = '0;
    mem_wready = 1'b0;
    ld_addr    = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state, then single store with memory ready.
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    cyc(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 32'h10);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h10);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h10);

    // Fill with memory stalled; fifth store stalls, then dequeue while full.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'h100 + 32'(i*4), 32'hA000 + 32'(i), 1'b0, 32'h104);
    cyc(1'b1, 32'h110, 32'hA004, 1'b1, 32'h110);
    cyc(1'b1, 32'h110, 32'hA004, 1'b0, 32'h110);
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h108);

    // Forwarding: youngest of two same-word stores wins; other word misses.
    cyc(1'b1, 32'h20, 32'h1111, 1'b0, 32'h22);
    cyc(1'b1, 32'h20, 32'h2222, 1'b0, 32'h22);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h22);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h24);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);

    // Ready toggling with continuous stores.
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 32'h200 + 32'(i*4), 32'hC000 + 32'(i), (i % 2) == 0, 32'h200 + 32'(i*4));
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Reset with three entries pending: nothing more must reach memory.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h300 + 32'(i*4), 32'hD000 + 32'(i), 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h300);

    // Random traffic over a small address window so forwarding hits occur.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 3) != 0,
          32'($urandom_range(0, 31)),
          $urandom,
          ($urandom % 2) == 0,
          32'($urandom_range(0, 31)));
      if (i == 250) do_reset();
    end

    // Final drain, bounded.
    for (int i = 0; i < 2*DEPTH && mq.size() > 0; i++)
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    chk("drain_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; SHALL be a power of two, 2..16.
REQ-002 Parameter AW, default 32, byte-address width.
REQ-003 Parameter DW, default 32, store-data width (word stores only).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 memwritem  input  1  memory-stage store request from the core.
REQ-007 aluresultm  input  AW  store byte address.
REQ-008 writedatam  input  DW  store data.
REQ-009 stallm  output  1  core SHALL hold its memory stage while high.
REQ-010 mem_wvalid  output  1  head entry valid toward data memory.
REQ-011 mem_waddr  output  AW  head entry address.
REQ-012 mem_wdata  output  DW  head entry data.
REQ-013 mem_wready  input  1  data memory accepts head entry this cycle.
REQ-014 ld_addr  input  AW  load byte address for forwarding lookup.
REQ-015 ld_hit  output  1  buffered store matches ld_addr.
REQ-016 ld_data  output  DW  forwarded store data.
REQ-017 count  output  $clog2(DEPTH+1)  occupied entries.
REQ-018 empty  output  1  count == 0.

Function
REQ-019 Circular FIFO: head/tail pointers wrap modulo DEPTH; full = (count == DEPTH).
REQ-020 Enqueue SHALL occur when memwritem && !full; entry written at tail, tail increments.
REQ-021 stallm SHALL equal memwritem && full (combinational); stalled store not captured; core re-presents it next cycle.
REQ-022 A dequeue in the same cycle as full does NOT free a slot for an enqueue that cycle; stallm stays high.
REQ-023 mem_wvalid SHALL equal !empty; mem_waddr/mem_wdata SHALL reflect head entry, stable while mem_wvalid && !mem_wready.
REQ-024 Dequeue SHALL occur when mem_wvalid && mem_wready; head increments; mem_wready while empty SHALL be ignored.
REQ-025 Simultaneous enqueue and dequeue (not full) SHALL leave count unchanged; enqueue into empty buffer SHALL assert mem_wvalid the following cycle (latency 1).
REQ-026 count SHALL increment on enqueue-only, decrement on dequeue-only; never exceed DEPTH nor underflow.
REQ-027 Stores SHALL drain in program order; throughput one store per cycle with mem_wready held high.

Reset
REQ-028 On reset high at a clock edge: head, tail, count SHALL clear; mem_wvalid=0, stallm=memwritem&&0=0 effectively 0 (buffer empty), ld_hit=0, empty=1.
REQ-029 Entry storage need not be cleared; outputs SHALL not expose it while empty.
REQ-030 Reset mid-drain SHALL discard all pending entries; no memory write after reset deasserts until a new enqueue.
REQ-031 memwritem asserted during reset SHALL NOT be captured.

Configuration
REQ-032 Macro STORE_BUF_FWD_EN defined: ld_hit SHALL be high when any valid entry satisfies addr[AW-1:2] == ld_addr[AW-1:2]; ld_data SHALL be the youngest matching entry's data; combinational, same cycle.
REQ-033 A store enqueued in the current cycle SHALL NOT be visible to forwarding until the next cycle.
REQ-034 Macro undefined: ld_hit and ld_data SHALL be tied to 0; ports remain present; no comparator logic.

Verification
REQ-035 Reset, then one store addr 0x10 data 0xDEADBEEF, mem_wready=1 -> mem_wvalid high next cycle with 0x10/0xDEADBEEF, count back to 0 one cycle later.
REQ-036 mem_wready=0, 5 stores with DEPTH=4 -> count=4, stallm high on 5th store, 5th captured only after one dequeue, drain order preserved.
REQ-037 Full buffer, memwritem and mem_wready both high -> dequeue occurs, count=3, stallm high that cycle, store captured next cycle, count=4.
REQ-038 mem_wready toggled 1/0 every cycle with continuous stores -> mem_waddr/mem_wdata stable during stalls, no loss or duplication.
REQ-039 FWD_EN: stores 0x20=0x1111 then 0x20=0x2222 buffered, ld_addr=0x22 -> ld_hit=1, ld_data=0x2222; ld_addr=0x24 -> ld_hit=0; without macro ld_hit=0 always.
REQ-040 Reset asserted with 3 entries pending -> mem_wvalid=0, count=0 next cycle, no further memory writes.
